// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults, log2 helper and configuration check for sync_fifo.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package sync_fifo_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_FIFO_DEPTH    = 16;
  localparam int DEF_AFULL_THRESH  = 14;
  localparam int DEF_AEMPTY_THRESH = 2;

  // Smallest r with 2**r >= v; used to derive ADDR_WIDTH from FIFO_DEPTH.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Depth must be a power of two (>= 4), address width must match it,
  // and the thresholds must be ordered inside the depth.
  function automatic bit cfg_ok(input int depth, input int aw,
                                input int afull, input int aempty);
    return (depth >= 4) && ((depth & (depth - 1)) == 0) &&
           (aw == clog2(depth)) && (aempty < afull) && (afull <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: write/read handshake, data and status bundle of sync_fifo.
// Latency: n/a (wires only).
// Backpressure: producer watches full, consumer watches empty / r_valid.
interface sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  w_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  // FIFO side
  modport slave (
    input  w_en, w_data, r_en,
    output r_data, r_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  // Producer/consumer side
  modport master (
    output w_en, w_data, r_en,
    input  r_data, r_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: single-clock dual-port storage, registered read port (+ comb port when SYNC_FIFO_FWFT_EN).
// Latency: write visible next cycle; registered read 1 cycle, comb read 0 cycles.
// Backpressure: none; caller guarantees legal addresses and enables.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
`ifdef SYNC_FIFO_FWFT_EN
  ,
  output logic [DATA_WIDTH-1:0] rdata_c_o
`endif
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array: written on write enable, never reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port: loads on read enable, otherwise holds the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata_c_o = mem_q[raddr_i];
`endif

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count, thresholds, overflow/underflow; FWFT read under SYNC_FIFO_FWFT_EN.
// Latency: r_en -> r_valid 1 cycle (FWFT: head word shown 1 cycle after its write).
// Backpressure: writes dropped when full, reads dropped when empty, each flagged by a 1-cycle pulse.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int ADDR_WIDTH    = clog2(FIFO_DEPTH),
  parameter int AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic       clk,
  input  logic       rst_n,
  sync_fifo_if.slave fifo
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  if (!cfg_ok(FIFO_DEPTH, ADDR_WIDTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_cfg_err
    $error("sync_fifo: illegal depth/address width/threshold combination");
  end

  logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  afull_q, afull_d, aempty_q, aempty_d;
  logic                  ovf_q, unf_q, rvalid_q;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Accept decisions use only the registered flags, so a full FIFO never
  // accepts a write in the same cycle as a read frees a slot (no pass-through).
  // In FWFT mode r_valid equals !empty, so the same rule pops the shown word.
  always_comb begin
    wr_acc = fifo.w_en & ~full_q;
    rd_acc = fifo.r_en & ~empty_q;
  end

  // Next pointers, occupancy and flags; flags derive from the next count so
  // they move on the same edge as count.
  always_comb begin
    wr_ptr_d = wr_ptr_q + CNT_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + CNT_W'(rd_acc);
    count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    full_d   = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (int'(count_d) >= AFULL_THRESH);
    aempty_d = (int'(count_d) <= AEMPTY_THRESH);
  end

  // Control state; reset discards everything in flight and restarts at address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= fifo.w_en & full_q;
      unf_q    <= fifo.r_en & empty_q;
      rvalid_q <= rd_acc;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (wr_acc),
    .waddr_i   (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i   (fifo.w_data),
    .re_i      (rd_acc),
    .raddr_i   (rd_ptr_q[ADDR_WIDTH-1:0]),
`ifdef SYNC_FIFO_FWFT_EN
    .rdata_o   (ram_rdata),
    .rdata_c_o (fifo.r_data)
`else
    .rdata_o   (ram_rdata)
`endif
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; the registered port is idle here.
  logic unused_rd;
  assign unused_rd    = ^{ram_rdata, rvalid_q};
  assign fifo.r_valid = ~empty_q;
`else
  assign fifo.r_data  = ram_rdata;
  assign fifo.r_valid = rvalid_q;
`endif

  assign fifo.full         = full_q;
  assign fifo.empty        = empty_q;
  assign fifo.almost_full  = afull_q;
  assign fifo.almost_empty = aempty_q;
  assign fifo.count        = count_q;
  assign fifo.overflow     = ovf_q;
  assign fifo.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (standard or FWFT build).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Each task checks its own scenario inline.
module tb_sync_fifo;

  localparam int DW = 8;
  localparam int AW = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) fif ();

  sync_fifo #(
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (16),
    .ADDR_WIDTH    (AW),
    .AFULL_THRESH  (14),
    .AEMPTY_THRESH (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fifo  (fif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fif.w_en = 1'b0; fif.r_en = 1'b0; fif.w_data = '0;
    step(); step();
    rst_n = 1'b1;
    repeat (5) step();
    n_tests++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", fif.empty); end
    n_tests++; if (fif.almost_empty !== 1'b1) begin n_fail++; $display("FAIL rst_aempty: got %b want 1", fif.almost_empty); end
    n_tests++; if (fif.full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", fif.full); end
    n_tests++; if (fif.almost_full !== 1'b0) begin n_fail++; $display("FAIL rst_afull: got %b want 0", fif.almost_full); end
    n_tests++; if (fif.count !== 5'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", fif.count); end
    n_tests++; if (fif.r_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", fif.r_valid); end
    n_tests++; if ({fif.overflow, fif.underflow} !== 2'b00) begin n_fail++; $display("FAIL rst_ovf_unf: got %b want 00", {fif.overflow, fif.underflow}); end
`ifndef SYNC_FIFO_FWFT_EN
    n_tests++; if (fif.r_data !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h want 00", fif.r_data); end
`endif
  endtask

`ifndef SYNC_FIFO_FWFT_EN
  task automatic test_fill_drain();
    for (int i = 1; i <= 16; i++) begin
      fif.w_en = 1'b1; fif.w_data = 8'(i);
      step();
      n_tests++; if (fif.count !== 5'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, fif.count, i); end
      n_tests++; if (fif.almost_full !== (i >= 14)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b want %b", i, fif.almost_full, (i >= 14)); end
      n_tests++; if (fif.full !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, fif.full, (i == 16)); end
      n_tests++; if (fif.almost_empty !== (i <= 2)) begin n_fail++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, fif.almost_empty, (i <= 2)); end
    end
    // rejected write at full
    fif.w_data = 8'hAA;
    step();
    fif.w_en = 1'b0;
    n_tests++; if (fif.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", fif.overflow); end
    n_tests++; if (fif.count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", fif.count); end
    step();
    n_tests++; if (fif.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", fif.overflow); end
    for (int i = 1; i <= 16; i++) begin
      fif.r_en = 1'b1;
      step();
      n_tests++; if (fif.r_valid !== 1'b1) begin n_fail++; $display("FAIL drain_rvalid[%0d]: got %b want 1", i, fif.r_valid); end
      n_tests++; if (fif.r_data !== 8'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h want %h", i, fif.r_data, 8'(i)); end
      n_tests++; if (fif.count !== 5'(16 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, fif.count, 16 - i); end
      n_tests++; if (fif.almost_empty !== ((16 - i) <= 2)) begin n_fail++; $display("FAIL drain_aempty[%0d]: got %b want %b", i, fif.almost_empty, ((16 - i) <= 2)); end
    end
    fif.r_en = 1'b0;
    step();
    n_tests++; if (fif.r_valid !== 1'b0) begin n_fail++; $display("FAIL drain_rvalid_end: got %b want 0", fif.r_valid); end
    n_tests++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", fif.empty); end
    // rejected read at empty
    fif.r_en = 1'b1;
    step();
    fif.r_en = 1'b0;
    n_tests++; if (fif.underflow !== 1'b1) begin n_fail++; $display("FAIL unf_pulse: got %b want 1", fif.underflow); end
    n_tests++; if (fif.r_valid !== 1'b0) begin n_fail++; $display("FAIL unf_rvalid: got %b want 0", fif.r_valid); end
    step();
    n_tests++; if (fif.underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear: got %b want 0", fif.underflow); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      fif.w_en = 1'b1; fif.w_data = 8'(8'h20 + i);
      step();
    end
    n_tests++; if (fif.count !== 5'd8) begin n_fail++; $display("FAIL b2b_fill: got %0d want 8", fif.count); end
    fif.r_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      fif.w_data = 8'(8'h28 + k);
      step();
      n_tests++; if (fif.count !== 5'd8) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 8", k, fif.count); end
      n_tests++; if (fif.r_data !== 8'(8'h20 + k) || fif.r_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h/%b want %h/1", k, fif.r_data, fif.r_valid, 8'(8'h20 + k)); end
    end
    fif.w_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      n_tests++; if (fif.r_data !== 8'(8'h48 + k)) begin n_fail++; $display("FAIL b2b_tail[%0d]: got %h want %h", k, fif.r_data, 8'(8'h48 + k)); end
    end
    fif.r_en = 1'b0;
    step();
    n_tests++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b want 1", fif.empty); end
  endtask

  task automatic test_simultaneous();
    // both requested while empty: only the write lands
    fif.w_en = 1'b1; fif.r_en = 1'b1; fif.w_data = 8'h77;
    step();
    fif.r_en = 1'b0;
    n_tests++; if (fif.count !== 5'd1) begin n_fail++; $display("FAIL sim_empty_count: got %0d want 1", fif.count); end
    n_tests++; if (fif.underflow !== 1'b1) begin n_fail++; $display("FAIL sim_empty_unf: got %b want 1", fif.underflow); end
    n_tests++; if (fif.r_valid !== 1'b0 || fif.empty !== 1'b0) begin n_fail++; $display("FAIL sim_empty_flags: got rv=%b em=%b want rv=0 em=0", fif.r_valid, fif.empty); end
    for (int i = 0; i < 15; i++) begin
      fif.w_data = 8'(8'h78 + i);
      step();
    end
    n_tests++; if (fif.full !== 1'b1) begin n_fail++; $display("FAIL sim_fill_full: got %b want 1", fif.full); end
    // both requested while full: only the read lands
    fif.r_en = 1'b1; fif.w_data = 8'hBB;
    step();
    fif.w_en = 1'b0; fif.r_en = 1'b0;
    n_tests++; if (fif.count !== 5'd15) begin n_fail++; $display("FAIL sim_full_count: got %0d want 15", fif.count); end
    n_tests++; if (fif.full !== 1'b0) begin n_fail++; $display("FAIL sim_full_flag: got %b want 0", fif.full); end
    n_tests++; if (fif.overflow !== 1'b1) begin n_fail++; $display("FAIL sim_full_ovf: got %b want 1", fif.overflow); end
    n_tests++; if (fif.r_data !== 8'h77 || fif.r_valid !== 1'b1) begin n_fail++; $display("FAIL sim_full_data: got %h/%b want 77/1", fif.r_data, fif.r_valid); end
    fif.r_en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      n_tests++; if (fif.r_data !== 8'(8'h78 + i)) begin n_fail++; $display("FAIL sim_drain[%0d]: got %h want %h", i, fif.r_data, 8'(8'h78 + i)); end
    end
    fif.r_en = 1'b0;
    step();
    n_tests++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL sim_drain_empty: got %b want 1", fif.empty); end
  endtask
`else
  task automatic test_fwft();
    fif.w_en = 1'b1; fif.w_data = 8'h5A;
    step();
    fif.w_en = 1'b0;
    n_tests++; if (fif.r_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_rvalid: got %b want 1", fif.r_valid); end
    n_tests++; if (fif.r_data !== 8'h5A) begin n_fail++; $display("FAIL fwft_rdata: got %h want 5a", fif.r_data); end
    n_tests++; if (fif.count !== 5'd1) begin n_fail++; $display("FAIL fwft_count: got %0d want 1", fif.count); end
    step();
    n_tests++; if (fif.r_data !== 8'h5A || fif.r_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_hold: got %h/%b want 5a/1", fif.r_data, fif.r_valid); end
    fif.r_en = 1'b1;
    step();
    fif.r_en = 1'b0;
    n_tests++; if (fif.empty !== 1'b1) begin n_fail++; $display("FAIL fwft_pop_empty: got %b want 1", fif.empty); end
    n_tests++; if (fif.r_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_pop_rvalid: got %b want 0", fif.r_valid); end
    n_tests++; if (fif.underflow !== 1'b0) begin n_fail++; $display("FAIL fwft_pop_unf: got %b want 0", fif.underflow); end
    fif.r_en = 1'b1;
    step();
    fif.r_en = 1'b0;
    n_tests++; if (fif.underflow !== 1'b1) begin n_fail++; $display("FAIL fwft_unf: got %b want 1", fif.underflow); end
  endtask
`endif

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      fif.w_en = 1'b1; fif.w_data = 8'(8'hE0 + i);
      step();
    end
    fif.w_en = 1'b0;
    n_tests++; if (fif.count !== 5'd5) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 5", fif.count); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (fif.count !== 5'd0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", fif.count); end
    n_tests++; if (fif.empty !== 1'b1 || fif.almost_empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b%b want 11", fif.empty, fif.almost_empty); end
    n_tests++; if (fif.r_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid: got %b want 0", fif.r_valid); end
    step();
    rst_n = 1'b1;
    fif.w_en = 1'b1; fif.w_data = 8'hC3;
    step();
    fif.w_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
    fif.r_en = 1'b1;
    step();
    fif.r_en = 1'b0;
`endif
    n_tests++; if (fif.r_data !== 8'hC3 || fif.r_valid !== 1'b1) begin n_fail++; $display("FAIL mid_after: got %h/%b want c3/1", fif.r_data, fif.r_valid); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    fif.w_en = 1'b0; fif.r_en = 1'b0; fif.w_data = '0;
    test_reset();
`ifndef SYNC_FIFO_FWFT_EN
    test_fill_drain();
    test_back_to_back();
    test_simultaneous();
`else
    test_fwft();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
